// File: rtl/uart_txq_if.sv
// rtl/uart_txq_if.sv - host write port and UART transmitter load port of the byte queue
interface uart_txq_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                ovf_clr;
  logic [7:0]          tx_data;
  logic                tx_write;
  logic                tx_ready;
  logic                busy;

  modport master (
    output wr_data, wr_en, ovf_clr, tx_ready,
    input  full, empty, level, overflow, tx_data, tx_write, busy
  );

  modport slave (
    input  wr_data, wr_en, ovf_clr, tx_ready,
    output full, empty, level, overflow, tx_data, tx_write, busy
  );
endinterface

// File: rtl/uart_txq.sv
// rtl/uart_txq.sv - circular byte FIFO feeding a UART transmitter one frame at a time
// Writes are dropped (and flagged sticky) when full; the FSM pops one byte per transmitter idle period.
module uart_txq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  uart_txq_if.slave  bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;
  logic                  overflow_q;
  logic [7:0]            tx_data_q;
  logic                  tx_write_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Full comes from the registered level only, so a same-cycle pop never frees a slot for a write.
  always_comb begin
    full    = (level_q == FULL_LVL);
    empty   = (level_q == '0);
    push    = bus.wr_en && !full;
    pop     = (state_q == IDLE) && !empty && bus.tx_ready;
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_write_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (bus.wr_en && full) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_write_q <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            tx_write_q <= 1'b0;
          end
        end
        ISSUE: begin
          tx_write_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          tx_write_q <= 1'b0;
          if (bus.tx_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_write_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_write = tx_write_q;
  assign bus.busy     = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_uart_txq.sv
// tb/tb_uart_txq.sv - self-checking bench for uart_txq with a transmitter model and byte scoreboard
module tb_uart_txq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;
  int   frame_len = 20;
  bit   hold = 1'b0;
  int   tx_cnt = 0;
  bit   prev_tw = 1'b0;
  int   n_emitted = 0;
  logic [7:0] sb [$];

  uart_txq_if #(.DEPTH_LOG2(4)) bus ();
  uart_txq #(.DEPTH_LOG2(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Transmitter model: ready drops the cycle after a load and stays low for frame_len cycles.
  always @(posedge clk) begin
    if (reset) tx_cnt <= 0;
    else if (bus.tx_write) tx_cnt <= frame_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_ready = (tx_cnt == 0) && !hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.tx_write) begin
      n_emitted++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_tx_write: got tx_data=%0h expected no pending byte", bus.tx_data);
      end else begin
        chk("tx_data_order", {24'h0, bus.tx_data}, {24'h0, sb.pop_front()});
      end
      chk("tx_write_one_cycle", {31'h0, prev_tw}, 32'h0);
      chk("tx_ready_at_write", {31'h0, bus.tx_ready}, 32'h1);
    end
    prev_tw = bus.tx_write;
  end

  task automatic wr(input logic [7:0] d, input bit accept);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    if (accept) sb.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, n < budget}, 32'h1);
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    bit         accept;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [21];
    int   base;
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 5'(i + 1), (i == 15), 1'b0};
    vecs[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 8'hFF, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0};

    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_level", {27'h0, bus.level}, 32'h0);
    chk("rst_empty", {31'h0, bus.empty}, 32'h1);
    chk("rst_full", {31'h0, bus.full}, 32'h0);
    chk("rst_overflow", {31'h0, bus.overflow}, 32'h0);
    chk("rst_tx_write", {31'h0, bus.tx_write}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);

    // Single byte latency: level at N+1, one-cycle pulse at N+2.
    wr(8'hA5, 1'b1);
    chk("single_level_n1", {27'h0, bus.level}, 32'h1);
    chk("single_no_write_n1", {31'h0, bus.tx_write}, 32'h0);
    @(negedge clk);
    chk("single_write_n2", {31'h0, bus.tx_write}, 32'h1);
    chk("single_data_n2", {24'h0, bus.tx_data}, 32'hA5);
    @(negedge clk);
    chk("single_write_n3", {31'h0, bus.tx_write}, 32'h0);
    chk("single_empty_after", {31'h0, bus.empty}, 32'h1);
    wait_drain(200, "single_drain");

    // Accepted write and pop in the same cycle leave level unchanged.
    wr(8'hC1, 1'b1);
    wr(8'hC2, 1'b1);
    chk("push_pop_level", {27'h0, bus.level}, 32'h1);
    wait_drain(400, "push_pop_drain");

    // Burst with a slow transmitter.
    frame_len = 160;
    base = n_emitted;
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    wait_drain(1000, "burst_drain");
    chk("burst_count", 32'(n_emitted - base), 32'd3);

    // Fill and overflow table with the transmitter held off.
    frame_len = 20;
    hold = 1'b1;
    for (int i = 0; i < 21; i++) begin
      bus.wr_en = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.ovf_clr = vecs[i].ovf_clr;
      if (vecs[i].accept) sb.push_back(vecs[i].wr_data);
      @(negedge clk);
      chk($sformatf("vec%0d_level", i), {27'h0, bus.level}, {27'h0, vecs[i].exp_level});
      chk($sformatf("vec%0d_full", i), {31'h0, bus.full}, {31'h0, vecs[i].exp_full});
      chk($sformatf("vec%0d_overflow", i), {31'h0, bus.overflow}, {31'h0, vecs[i].exp_ovf});
    end
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;

    // A pop in the same cycle as a write while full must not admit the write.
    hold = 1'b0;
    wr(8'hFF, 1'b0);
    chk("full_pop_level", {27'h0, bus.level}, 32'd15);
    chk("full_pop_overflow", {31'h0, bus.overflow}, 32'h1);
    chk("full_pop_write", {31'h0, bus.tx_write}, 32'h1);
    wait_drain(2000, "fill_drain");
    chk("fill_level_zero", {27'h0, bus.level}, 32'h0);

    // Wrap-around: 40 bytes through 16 slots.
    frame_len = 4;
    base = n_emitted;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) wr(8'(b * 8 + k), 1'b1);
      wait_drain(400, "wrap_drain");
    end
    chk("wrap_count", 32'(n_emitted - base), 32'd40);
    chk("wrap_level_zero", {27'h0, bus.level}, 32'h0);

    // Reset while waiting on the transmitter with 5 bytes queued.
    frame_len = 160;
    for (int k = 0; k < 6; k++) wr(8'(8'hE0 + k), 1'b1);
    repeat (5) @(negedge clk);
    chk("pre_reset_level", {27'h0, bus.level}, 32'd5);
    chk("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_level", {27'h0, bus.level}, 32'h0);
    chk("mid_reset_empty", {31'h0, bus.empty}, 32'h1);
    chk("mid_reset_tx_write", {31'h0, bus.tx_write}, 32'h0);
    chk("mid_reset_busy", {31'h0, bus.busy}, 32'h0);
    base = n_emitted;
    repeat (200) @(negedge clk);
    chk("post_reset_silent", 32'(n_emitted - base), 32'h0);
    wr(8'h5A, 1'b1);
    wait_drain(400, "post_reset_drain");
    chk("post_reset_count", 32'(n_emitted - base), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
